// File: rtl/octal_enc_pkg.sv
// Shared widths, select encodings and types for the octal priority encoder.
// Pure declarations; no logic, no latency, no flow control.
package octal_enc_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 3;

    localparam logic SEL_MSB_FIRST = 1'b0;
    localparam logic SEL_LSB_FIRST = 1'b1;

    typedef logic [IN_W_DEF-1:0]  req_vec_t;
    typedef logic [OUT_W_DEF-1:0] req_idx_t;

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority encoder: index of the winning request bit, plus any/multi flags.
// Latency: zero (purely combinational). Backpressure: none.
// Optional macro ONEHOT_CHECK_EN adds the multi output (popcount > 1).
module prio_enc_core
    import octal_enc_pkg::*;
#(
    parameter  int IN_W  = IN_W_DEF,
    localparam int OUT_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  vec,
    input  logic             sel,
    output logic [OUT_W-1:0] index,
    output logic             any
`ifdef ONEHOT_CHECK_EN
    ,
    output logic             multi
`endif
);

    // The last match in scan order wins, so the scan runs toward the preferred end.
    always_comb begin
        index = '0;
        if (sel == SEL_MSB_FIRST) begin
            for (int i = 0; i < IN_W; i++) begin
                if (vec[i]) index = OUT_W'(i);
            end
        end else begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (vec[i]) index = OUT_W'(i);
            end
        end
    end

    assign any = |vec;

`ifdef ONEHOT_CHECK_EN
    assign multi = ($countones(vec) > 1);
`endif

endmodule

// File: rtl/octal_priority_encoder.sv
// Registered 8-to-3 priority encoder; sel=0 picks highest set bit, sel=1 lowest.
// Latency: 1 cycle, outputs fully registered. Backpressure: none, accepts every cycle.
// Macro ONEHOT_CHECK_EN adds the registered multi_hot output.
module octal_priority_encoder
    import octal_enc_pkg::*;
#(
    parameter  int IN_W  = IN_W_DEF,
    localparam int OUT_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  octal_in,
    input  logic             sel,
    output logic [OUT_W-1:0] binary_out,
    output logic             valid
`ifdef ONEHOT_CHECK_EN
    ,
    output logic             multi_hot
`endif
);

    logic [OUT_W-1:0] core_index;
    logic             core_any;
`ifdef ONEHOT_CHECK_EN
    logic             core_multi;
`endif

    prio_enc_core #(
        .IN_W (IN_W)
    ) u_core (
        .vec   (octal_in),
        .sel   (sel),
        .index (core_index),
        .any   (core_any)
`ifdef ONEHOT_CHECK_EN
        ,
        .multi (core_multi)
`endif
    );

    // Core already yields index 0 for a zero vector, so no stale index can be held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary_out <= '0;
            valid      <= 1'b0;
        end else begin
            binary_out <= core_index;
            valid      <= core_any;
        end
    end

`ifdef ONEHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_hot <= 1'b0;
        end else begin
            multi_hot <= core_multi;
        end
    end
`endif

endmodule

// File: tb/tb_octal_priority_encoder.sv
// Directed bench for octal_priority_encoder with hand-computed expectations.
module tb_octal_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] octal_in;
    logic       sel;
    logic [2:0] binary_out;
    logic       valid;
`ifdef ONEHOT_CHECK_EN
    logic       multi_hot;
`endif

    int checks = 0;
    int passed = 0;
    int failed = 0;

    octal_priority_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .octal_in   (octal_in),
        .sel        (sel),
        .binary_out (binary_out),
        .valid      (valid)
`ifdef ONEHOT_CHECK_EN
        ,
        .multi_hot  (multi_hot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic chk_outputs(input string tag, input int exp_idx, input int exp_vld,
                               input int exp_multi);
        chk({tag, ".idx"}, int'(binary_out), exp_idx);
        chk({tag, ".vld"}, int'(valid), exp_vld);
`ifdef ONEHOT_CHECK_EN
        chk({tag, ".multi"}, int'(multi_hot), exp_multi);
`else
        if (exp_multi < 0) $display("unexpected multi expectation in %s", tag);
`endif
    endtask

    // Drive a vector/sel pair between edges, then check one cycle later.
    task automatic step(input string tag, input logic [7:0] v, input logic s,
                        input int exp_idx, input int exp_vld, input int exp_multi);
        @(negedge clk);
        octal_in = v;
        sel      = s;
        @(posedge clk);
        #1;
        chk_outputs(tag, exp_idx, exp_vld, exp_multi);
    endtask

    initial begin
        rst_n    = 1'b0;
        octal_in = 8'hFF;
        sel      = 1'b0;

        // Reset held: inputs active, outputs must stay cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel = ~sel;
            @(posedge clk);
            #1;
            chk_outputs("reset_hold", 0, 0, 0);
        end

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'(1 << i);
            step("onehot_sel0", v, 1'b0, i, 1, 0);
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'(1 << i);
            step("onehot_sel1", v, 1'b1, i, 1, 0);
        end

        step("mh81_sel0", 8'h81, 1'b0, 7, 1, 1);
        step("mh81_sel1", 8'h81, 1'b1, 0, 1, 1);
        step("mh3c_sel0", 8'h3C, 1'b0, 5, 1, 1);
        step("mh3c_sel1", 8'h3C, 1'b1, 2, 1, 1);
        step("allones_sel0", 8'hFF, 1'b0, 7, 1, 1);
        step("allones_sel1", 8'hFF, 1'b1, 0, 1, 1);

        step("pre_zero", 8'h80, 1'b0, 7, 1, 0);
        step("zero", 8'h00, 1'b0, 0, 0, 0);
        step("zero_sel1", 8'h00, 1'b1, 0, 0, 0);

        step("simul_a", 8'h18, 1'b0, 4, 1, 1);
        step("simul_b", 8'h18, 1'b1, 3, 1, 1);
        step("simul_c", 8'h60, 1'b0, 6, 1, 1);

        // Mid-operation async reset: outputs clear between clock edges.
        step("pre_async", 8'hC0, 1'b0, 7, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("async_clear", 0, 0, 0);
        @(posedge clk);
        #1;
        chk_outputs("async_hold", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        step("post_reset", 8'h24, 1'b1, 2, 1, 1);
        step("post_reset_b", 8'h24, 1'b0, 5, 1, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
